div_32bit_seq: RTL and testbench



---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 41 ++++
 rtl/div_32bit_seq.sv | 175 +++++++++++++++++
 tb/tb_div_32bit_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared constants for the sequential unsigned divider
//               (div_32bit_seq) and its iteration step (div_step).
//               - DIV_WIDTH    : default operand / result width
//               - ST_*         : FSM state encoding
//               - DBZ_QUOTIENT : quotient reported for a zero divisor
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring-division iteration (purely combinational).
//               Shifts the next dividend bit into the partial remainder,
//               performs a WIDTH+1-bit trial subtraction of the divisor and
//               either keeps the difference (quotient bit 1) or restores the
//               shifted remainder (quotient bit 0).
// Ports       : rem      in  WIDTH  current partial remainder
//               q_msb    in  1      dividend bit entering the remainder
//               divisor  in  WIDTH  captured divisor
//               rem_next out WIDTH  partial remainder after this step
//               q_bit    out 1      quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] w_trial;

    // {rem, q_msb} is the shifted remainder at WIDTH+1 bits; the extra bit
    // keeps the borrow visible as the sign of the difference.
    assign w_trial  = {rem, q_msb} - {1'b0, divisor};

    assign q_bit    = ~w_trial[WIDTH];

    // The remainder always stays below the divisor, so the restored value
    // has a zero top bit and fits in WIDTH bits.
    assign rem_next = q_bit ? w_trial[WIDTH-1:0] : {rem[WIDTH-2:0], q_msb};

endmodule : div_step
`default_nettype wire

// File: rtl/div_32bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_32bit_seq
// Description : Multi-cycle unsigned restoring divider (DIVU, HI/LO).
//               One quotient bit per clock, WIDTH iterations per division.
//               A zero divisor completes in one cycle with an all-ones
//               quotient, remainder = dividend and div_by_zero set.
// Ports       : clock        in  1      rising-edge clock
//               reset        in  1      synchronous active-high reset
//               start        in  1      request, sampled only when not busy
//               dividend     in  WIDTH  numerator, captured on accept
//               divisor      in  WIDTH  denominator, captured on accept
//               quotient     out WIDTH  registered result (LO)
//               remainder    out WIDTH  registered result (HI)
//               busy         out 1      high while iterating
//               done         out 1      one-cycle completion pulse
//               div_by_zero  out 1      completion was a divide by zero
// Revision    : 1.0 - initial release
// ============================================================================
module div_32bit_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] LAST_COUNT   = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] DBZ_QUOT_W   = WIDTH'(DBZ_QUOTIENT) | {WIDTH{1'b1}};

    // FSM
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             w_accept;

    // Iteration datapath
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_divisor;

    // Result registers
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_last;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_shift_next;

    assign w_last       = (r_count == LAST_COUNT);
    assign w_div_zero   = (divisor == '0);
    assign w_shift_next = {r_shift[WIDTH-2:0], w_q_bit};

    div_step #(
        .WIDTH    (WIDTH)
    ) u_div_step (
        .rem      (r_rem),
        .q_msb    (r_shift[WIDTH-1]),
        .divisor  (r_divisor),
        .rem_next (w_rem_next),
        .q_bit    (w_q_bit)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // DONE accepts a new start exactly like IDLE so that the control unit
    // can issue divisions back to back.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_div_zero ? ST_DONE : ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from the state register only
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // Results are only written at completion, so the outputs never show
    // intermediate iteration values.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count     <= '0;
            r_rem       <= '0;
            r_shift     <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            if (w_div_zero) begin
                r_quotient  <= DBZ_QUOT_W;
                r_remainder <= dividend;
                r_dbz       <= 1'b1;
            end else begin
                r_divisor   <= divisor;
                r_rem       <= '0;
                r_shift     <= dividend;
                r_count     <= '0;
            end
        end else if (r_state == ST_RUN) begin
            r_rem   <= w_rem_next;
            r_shift <= w_shift_next;
            r_count <= r_count + CNT_W'(1);
            if (w_last) begin
                r_quotient  <= w_shift_next;
                r_remainder <= w_rem_next;
                r_dbz       <= 1'b0;
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule : div_32bit_seq
`default_nettype wire

// File: tb/tb_div_32bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_32bit_seq
// Description : Self-checking bench for div_32bit_seq. Expected results are
//               queued when an operation is issued and compared when done
//               pulses; busy, latency and result holding are checked every
//               cycle of an operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_32bit_seq;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    logic         clock;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    exp_t         sb[$];
    logic [W-1:0] hold_q;
    logic [W-1:0] hold_r;
    int           n_checks;
    int           n_fail;

    div_32bit_seq #(
        .WIDTH       (W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Drive a request at the current point (away from the clock edge) and
    // hold it through exactly one accept edge, then scramble the operands.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        e.dbz = (b == '0);
        e.q   = e.dbz ? {W{1'b1}} : a / b;
        e.r   = e.dbz ? a : a % b;
        e.lat = e.dbz ? 1 : W + 1;
        if (push) sb.push_back(e);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Follow one operation cycle by cycle from the accept edge. When poke>0
    // a competing start (50/5) is raised during that cycle.
    task automatic collect(input int poke);
        exp_t e;
        int   n;
        bit   seen;
        n    = 0;
        seen = 1'b0;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 1, 0);
            return;
        end
        e = sb[0];
        while (!seen && n < 40) begin
            @(negedge clock);
            n++;
            if (poke > 0 && n == poke) begin
                start    = 1'b1;
                dividend = 50;
                divisor  = 5;
            end
            if (poke > 0 && n == poke + 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                check_eq("latency", n, e.lat);
                check_eq("busy_in_done", busy, 0);
                check_eq("quotient", quotient, e.q);
                check_eq("remainder", remainder, e.r);
                check_eq("div_by_zero", div_by_zero, e.dbz);
                hold_q = e.q;
                hold_r = e.r;
            end else begin
                check_eq("busy", busy, (e.lat > 1) ? 1 : 0);
                check_eq("q_hold", quotient, hold_q);
                check_eq("r_hold", remainder, hold_r);
            end
        end
        if (poke > 0) start = 1'b0;
        if (!seen) begin
            check_eq("done_timeout", 0, 1);
            void'(sb.pop_front());
        end
    endtask

    task automatic one_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        issue(a, b, 1'b1);
        collect(0);
    endtask

    initial begin
        int ndone;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] edge_a [10];
        logic [W-1:0] edge_b [10];

        n_checks = 0;
        n_fail   = 0;
        hold_q   = '0;
        hold_r   = '0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_q", quotient, 0);
        check_eq("rst_r", remainder, 0);
        check_eq("rst_dbz", div_by_zero, 0);

        // Basic division
        one_op(100, 7);

        // Back-to-back: second start raised in the done cycle
        @(negedge clock);
        issue(32'hFFFF_FFFF, 32'h1, 1'b1);
        collect(0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        collect(0);

        // Divide by zero
        one_op(5, 0);

        // Start while busy is ignored; exactly one done pulse
        @(negedge clock);
        issue(3, 10, 1'b1);
        collect(5);
        ndone = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check_eq("extra_done", ndone, 0);
        check_eq("ignored_q", quotient, 0);
        check_eq("ignored_r", remainder, 3);

        // Reset in the middle of a division
        @(negedge clock);
        issue(1000, 3, 1'b0);
        repeat (9) @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        hold_q = '0;
        hold_r = '0;
        @(negedge clock);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_q", quotient, 0);
        check_eq("abort_r", remainder, 0);
        check_eq("abort_dbz", div_by_zero, 0);
        ndone = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check_eq("abort_no_done", ndone, 0);
        one_op(1000, 3);

        // Boundary operand sweep
        edge_a = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7, 32'h1234_5678,
                   32'hFFFF_FFFE, 32'h1, 32'h8000_0000, 32'hDEAD_BEEF};
        edge_b = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h7, 32'h1,
                   32'hFFFF_FFFF, 32'h2, 32'h8000_0001, 32'h0001_0000};
        for (int i = 0; i < 10; i++) one_op(edge_a[i], edge_b[i]);

        // Random sweep with mixed divisor magnitudes
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case (i % 4)
                0:       rb = $urandom;
                1:       rb = W'($urandom_range(0, 15));
                2:       rb = ra + W'($urandom_range(1, 1000));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            one_op(ra, rb);
        end

        check_eq("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_32bit_seq
`default_nettype wire
